// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mult_div_pkg
//  Description : Constants and types shared by the Booth multiplier and the
//                sequential divider of the mult/div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_div_pkg;

  // Operand / result width of the unit.
  localparam int WIDTH = 32;

  // Values of the MultOrDiv operation select.
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Number of restoring shift-subtract steps per division.
  localparam int ITER = 32;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIX   = 2'd2,
    DZERO = 2'd3
  } div_state_t;

endpackage : mult_div_pkg
`default_nettype wire

// File: rtl/div_seq_if.sv
`default_nettype none
// ============================================================================
//  Interface   : div_seq_if
//  Description : Request / result bundle of the sequential divider. The
//                master issues operations, the slave (divider) returns the
//                hi/lo results and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_if #(
  parameter int WIDTH = mult_div_pkg::WIDTH
);

  logic             start;
  logic             MultOrDiv;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, MultOrDiv, A, B,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, MultOrDiv, A, B,
    output hi, lo, busy, done, div_zero
  );

endinterface : div_seq_if
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring division iteration on unsigned magnitudes:
//                shift {rem, quo} left by one, trial-subtract the divisor and
//                keep the difference when it is non-negative.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = mult_div_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // rem < divisor <= 2^(WIDTH-1), so the shifted remainder fits WIDTH+1 bits
  // and the trial difference never wraps; its top bit is a true sign.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift in the next dividend bit and decide the quotient bit.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Sequential signed divider (MIPS DIV semantics, truncation
//                toward zero). Quotient on lo, remainder on hi. One restoring
//                step per cycle on operand magnitudes, then a sign-fix cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq #(
  parameter int WIDTH = mult_div_pkg::WIDTH
) (
  input  logic      clock,
  input  logic      reset,
  div_seq_if.slave  bus
);

  import mult_div_pkg::*;

  localparam int CNT_W = $clog2(ITER + 1);

  div_state_t       state;
  div_state_t       state_nxt;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             sign_q;
  logic             sign_r;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic             done_r;
  logic             dz_r;

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvsr),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: accept only a divide request while idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = b_zero ? DZERO : RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      DZERO:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request qualification and operand magnitudes. The most negative value
  // negates to itself, which is exactly its magnitude read as unsigned.
  always_comb begin
    accept = (state == IDLE) && bus.start && (bus.MultOrDiv == OP_DIV);
    b_zero = (bus.B == '0);
    a_mag  = bus.A[WIDTH-1] ? -bus.A : bus.A;
    b_mag  = bus.B[WIDTH-1] ? -bus.B : bus.B;
  end

  // Datapath and result registers, advanced according to the current state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      cnt    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            sign_r <= bus.A[WIDTH-1];
            quo    <= a_mag;
            dvsr   <= b_mag;
            rem    <= '0;
            cnt    <= CNT_W'(ITER);
            busy_r <= !b_zero;
          end
        end
        RUN: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          lo_r   <= sign_q ? -quo : quo;
          hi_r   <= sign_r ? -rem : rem;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          dz_r   <= 1'b0;
        end
        DZERO: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          dz_r   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule : div_seq
`default_nettype wire
